// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: decode control-word layout, pipeline bubble
// encoding, base opcodes and the skid-buffer occupancy states.
package riscv_pkg;

  localparam int CTRL_W = 13;

  localparam int CTRL_ALU_SRC1_HI = 12;
  localparam int CTRL_ALU_SRC1_LO = 11;
  localparam int CTRL_ALU_SRC2_HI = 10;
  localparam int CTRL_ALU_SRC2_LO = 9;
  localparam int CTRL_MEM_TO_REG  = 8;
  localparam int CTRL_REG_WRITE   = 7;
  localparam int CTRL_MEM_READ    = 6;
  localparam int CTRL_MEM_WRITE   = 5;
  localparam int CTRL_BRANCH      = 4;
  localparam int CTRL_BRANCH_BASE = 3;
  localparam int CTRL_ALU_OP_HI   = 2;
  localparam int CTRL_ALU_OP_LO   = 0;

  // alu_op=101 with every side-effect bit clear; EX executes it as a NOP.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 13'h0005;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b11
  } sb_state_e;

endpackage

// File: rtl/id_ex_buffer_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-side outputs and flush.
// master = the surrounding pipeline (ID/EX/hazard unit), slave = the buffer.
interface id_ex_buffer_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 13
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic              in_funct7_5;

  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [2:0]        out_funct3;
  logic              out_funct7_5;

  modport master (
    output flush, in_valid, in_ctrl, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_funct3, in_funct7_5, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_rs1_data, out_rs2_data,
           out_imm, out_rs1, out_rs2, out_rd, out_funct3, out_funct7_5
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1, in_rs2, in_rd, in_funct3, in_funct7_5, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_rs1_data, out_rs2_data,
           out_imm, out_rs1, out_rs2, out_rd, out_funct3, out_funct7_5
  );
endinterface

// File: rtl/id_ex_buffer_skid_buf.sv
// Generic two-entry skid buffer: main entry M drives the output, skid entry S
// catches the one extra beat accepted while in_ready is still high.
module skid_buf
  import riscv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  sb_state_e    state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic [W-1:0] m_data_q, m_data_d;
  logic [W-1:0] s_data_q, s_data_d;
  logic         m_v, s_v, in_fire, out_fire;
  logic         load_m_in, load_m_s, load_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SB_EMPTY;
      in_ready_q <= 1'b1;
      m_data_q   <= '0;
      s_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_d = SB_EMPTY;
    end else begin
      unique case (state_q)
        SB_EMPTY: if (in_fire) begin
          state_d   = SB_ONE;
          load_m_in = 1'b1;
        end
        SB_ONE: begin
          if (in_fire && out_fire) begin
            load_m_in = 1'b1;
          end else if (in_fire) begin
            state_d = SB_FULL;
            load_s  = 1'b1;
          end else if (out_fire) begin
            state_d = SB_EMPTY;
          end
        end
        SB_FULL: if (out_fire) begin
          state_d  = SB_ONE;
          load_m_s = 1'b1;
        end
        default: state_d = SB_EMPTY;
      endcase
    end
    m_data_d   = load_m_in ? in_data : (load_m_s ? s_data_q : m_data_q);
    s_data_d   = load_s ? in_data : s_data_q;
    // Registered ready: it only reflects our own next occupancy, never out_ready.
    in_ready_d = (state_d != SB_FULL);
  end

  always_comb begin
    m_v       = (state_q != SB_EMPTY);
    s_v       = (state_q == SB_FULL);
    in_fire   = in_valid & in_ready_q;
    out_fire  = m_v & out_ready;
    in_ready  = in_ready_q;
    out_valid = m_v;
    out_data  = m_data_q;
  end

  logic unused_s_v;
  assign unused_s_v = s_v;

endmodule

// File: rtl/id_ex_buffer.sv
// ID/EX pipeline register of the RV32I core: packs the decoded fields into one
// payload, buffers it in a skid buffer and forces a NOP control word on bubbles.
module id_ex_buffer #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 13
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_buffer_if.slave bus
);

  localparam int PAY_W = CTRL_W + 4 * XLEN + 3 * 5 + 3 + 1;

  logic [PAY_W-1:0]  in_data;
  logic [PAY_W-1:0]  out_data;
  logic [CTRL_W-1:0] ctrl_raw;
  logic              out_valid;

  assign in_data = {bus.in_ctrl, bus.in_pc, bus.in_rs1_data, bus.in_rs2_data,
                    bus.in_imm, bus.in_rs1, bus.in_rs2, bus.in_rd,
                    bus.in_funct3, bus.in_funct7_5};

  skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );

  assign {ctrl_raw, bus.out_pc, bus.out_rs1_data, bus.out_rs2_data,
          bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
          bus.out_funct3, bus.out_funct7_5} = out_data;

  assign bus.out_valid = out_valid;
  // A stale control word must never leak side effects into EX.
  assign bus.out_ctrl  = out_valid ? ctrl_raw : CTRL_W'(riscv_pkg::CTRL_BUBBLE);

endmodule

// File: doc/id_ex_buffer.md
# id_ex_buffer

- Two-entry skid buffer forming the ID/EX pipeline boundary of the 5-stage RV32I core.
- Captures the 13-bit decode control word and the decoded operands from the ID stage, and presents them to EX.
- Uses a valid/ready handshake with a fully registered `in_ready`, so there is no combinational path from EX back-pressure into decode.
- `flush` squashes both entries, for taken branches and jumps.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `CTRL_W`, 13, control-word width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush` in 1: squash all held entries; highest priority.
- `in_valid` in 1: ID presents a decoded instruction.
- `in_ready` out 1: buffer can accept; registered.
- `in_ctrl` in CTRL_W: `{alu_src1[12:11], alu_src2[10:9], mem_to_reg[8], reg_write[7], mem_read[6], mem_write[5], branch[4], branch_base[3], alu_op[2:0]}`.
- `in_pc`, `in_rs1_data`, `in_rs2_data`, `in_imm` in XLEN each: operands.
- `in_rs1`, `in_rs2`, `in_rd` in 5 each: register indices.
- `in_funct3` in 3, `in_funct7_5` in 1: ALU sub-op fields.
- `out_valid` out 1: EX-side entry valid.
- `out_ready` in 1: EX accepts.
- `out_ctrl`, `out_pc`, `out_rs1_data`, `out_rs2_data`, `out_imm`, `out_rs1`, `out_rs2`, `out_rd`, `out_funct3`, `out_funct7_5` out: mirror of the input fields.

## Operation
- Storage:
  - main entry (M), which drives `out_*`;
  - skid entry (S).
  - Each has a valid bit (`m_v`, `s_v`).
- Handshake:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
  - `out_valid = m_v`.
  - `in_ready = ~s_v` (a flop, not derived from `out_ready`).
- States:
  - EMPTY (`m_v=0, s_v=0`).
  - ONE (`m_v=1, s_v=0`).
  - FULL (`m_v=1, s_v=1`).
- Transitions (no flush):
  - EMPTY, `in_fire` → ONE. M loads the input.
  - ONE, `in_fire & out_fire` → ONE. M loads the input.
  - ONE, `in_fire & ~out_fire` → FULL. S loads the input.
  - ONE, `~in_fire & out_fire` → EMPTY.
  - FULL, `out_fire` → ONE. M loads S, and S clears. No `in_fire` is possible in FULL.
  - All other cases hold state.
- Bubble:
  - When `m_v=0`, `out_ctrl` is forced to `CTRL_BUBBLE = 13'h0005` (alu_op=101, all other fields 0).
  - The other `out_*` fields hold their last value.
  - EX treats `CTRL_BUBBLE` as a NOP; `reg_write`, `mem_read`, `mem_write` and `branch` are therefore never asserted from an invalid entry.
- Flush:
  - On the next edge, `m_v` and `s_v` are cleared, giving EMPTY.
  - Any `in_fire` or `out_fire` in the flush cycle is discarded for state purposes.
  - `in_ready` is 1 the cycle after.
  - `flush` overrides every transition above.
- Payload is never modified; the block has no arithmetic.

## Timing
- Reset (`rst_n=0` at an edge) gives:
  - `m_v=0`, `s_v=0`, `in_ready=1`, `out_valid=0`;
  - `out_ctrl=13'h0005`;
  - all other `out_*` = 0.
- Reset mid-operation drops held entries exactly like flush.
- Latency: `in_fire` at edge N puts the entry on `out_*` with `out_valid=1` after edge N+1 (one cycle) when entering from EMPTY, or from ONE with `out_fire`.
- Throughput: one instruction per cycle while `out_ready=1`.
- Back-pressure: `in_ready` falls one cycle after FULL is entered. It rises the cycle after the `out_fire` that drains S.
- Ordering: strict FIFO. The S entry is always older than any later input.
- `rst_n` takes precedence over `flush`.

## Structure
- Shared package `riscv_pkg` holds:
  - `CTRL_W`;
  - ctrl bit-position localparams (`CTRL_ALU_SRC1_HI` … `CTRL_ALU_OP_LO`);
  - `CTRL_BUBBLE = 13'h0005`;
  - opcode constants shared with the decode control unit.
- Natural sub-module: `skid_buf`. It is generic, parameterised by payload width, and holds the M/S registers, valid bits and `in_ready` flop.
- `id_ex_buffer` concatenates the fields into one payload vector, instantiates `skid_buf`, splits the fields back out, and applies the bubble mux on `out_ctrl`.

## Test plan
- **Reset:** hold `rst_n=0` 2 cycles with `in_valid=1` → `out_valid=0`, `out_ctrl=13'h0005`, `in_ready=1`. No capture.
- **Streaming:** `out_ready=1`; feed pc=0x0, 0x4, 0x8 on consecutive cycles → `out_pc` shows 0x0, 0x4, 0x8 one cycle later each, `in_ready` stays 1.
- **Back-pressure:** `out_ready=0`; send pc=0x10 then pc=0x14 → `in_ready=0` the following cycle and `out_pc=0x10`. Raise `out_ready` → 0x10 then 0x14 are delivered, then `in_ready=1`.
- **Flush when FULL:** while FULL with `in_valid=1`, assert `flush` one cycle → next cycle `out_valid=0`, `out_ctrl=13'h0005`, `in_ready=1`. No held or incoming pc ever appears.
- **Load-word field fidelity:** in_ctrl=13'b00_01_1_1_1_0_0_0_000, rd=5, imm=0x8 → identical ctrl, rd=5, imm=0x8 at the output. With a bubble (`m_v=0`), `reg_write` and `mem_read` read 0.
